// File: rtl/fifo_producer.sv
// fifo_producer -- write-side engine of the async FIFO.
//
// Accepts words from a source over a wr_req/wr_ready handshake, holds them
// in a small staging queue and drains the queue into FIFO memory through
// w_en/mem_data_in whenever the core reports f_full=0. Everything lives in
// the w_clk domain; pointer synchronisation stays in the FIFO core.
//
// Ports:
//   w_clk        write-domain clock (posedge)
//   wrst         synchronous active-high reset
//   wr_req       source presents data_in this cycle
//   data_in      source data word
//   wr_ready     staging queue can take a word this cycle
//   f_full       FIFO full flag from the core (w_clk domain)
//   w_en         FIFO memory write strobe
//   mem_data_in  word written to FIFO memory when w_en=1 (queue head)
//   stage_count  occupied staging entries, 0..STAGE_DEPTH
//   ovf_err      sticky: wr_req seen while wr_ready=0
//
// Optional build macro FIFO_PRODUCER_STATS_EN adds:
//   wr_count     32-bit count of memory writes (w_en edges), wraps
//   stall_cycles 32-bit count of cycles spent in STALL, wraps
module fifo_producer #(
  parameter int DATA_WIDTH  = 32,
  parameter int STAGE_DEPTH = 4,
  localparam int CW         = $clog2(STAGE_DEPTH) + 1
) (
  input  logic                  w_clk,
  input  logic                  wrst,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  wr_ready,
  input  logic                  f_full,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [CW-1:0]         stage_count,
`ifdef FIFO_PRODUCER_STATS_EN
  output logic [31:0]           wr_count,
  output logic [31:0]           stall_cycles,
`endif
  output logic                  ovf_err
);

  localparam int PW = $clog2(STAGE_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [STAGE_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  push, pop;

  // Handshake and drain strobes. wr_ready looks only at the registered
  // count, so a pop in the same cycle never opens a slot in a full queue.
  // state_q is IDLE exactly when the registered count is zero.
  always_comb begin
    wr_ready = (cnt_q < CW'(STAGE_DEPTH)) && !wrst;
    w_en     = (state_q != IDLE) && !f_full && !wrst;
    push     = wr_req && wr_ready;
    pop      = w_en;
  end

  // Next-state for pointers, count and sticky overflow. Pointers wrap
  // naturally because STAGE_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q | (wr_req && !wr_ready && !wrst);
  end

  // State follows the count and f_full as they stand after the edge.
  always_comb begin
    state_d = state_q;
    if (cnt_d == '0)  state_d = IDLE;
    else if (f_full)  state_d = STALL;
    else              state_d = SEND;
  end

  always_ff @(posedge w_clk) begin
    if (wrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      // Storage is cleared so mem_data_in reads zero out of reset and no
      // discarded word can resurface later.
      for (int i = 0; i < STAGE_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      if (push) mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Head entry is registered storage: no combinational path from data_in.
  assign mem_data_in = mem_q[rd_ptr_q];
  assign stage_count = cnt_q;
  assign ovf_err     = ovf_q;

`ifdef FIFO_PRODUCER_STATS_EN
  logic [31:0] wr_count_q, stall_cycles_q;

  always_ff @(posedge w_clk) begin
    if (wrst) begin
      wr_count_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (w_en)             wr_count_q     <= wr_count_q + 32'd1;
      if (state_q == STALL) stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign wr_count     = wr_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fifo_producer.sv
`timescale 1ns/1ps
module tb_fifo_producer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          w_clk = 1'b0;
  logic          wrst;
  logic          wr_req;
  logic [DW-1:0] data_in;
  logic          wr_ready;
  logic          f_full;
  logic          w_en;
  logic [DW-1:0] mem_data_in;
  logic [CW-1:0] stage_count;
  logic          ovf_err;

  logic          f_main = 1'b0;
  logic          f_tog  = 1'b0;
  logic          tog_en = 1'b0;
  logic          mon_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] sb [$];
  logic          m_ovf = 1'b0;

  assign f_full = tog_en ? f_tog : f_main;

  fifo_producer #(.DATA_WIDTH(DW), .STAGE_DEPTH(DEPTH)) dut (
    .w_clk       (w_clk),
    .wrst        (wrst),
    .wr_req      (wr_req),
    .data_in     (data_in),
    .wr_ready    (wr_ready),
    .f_full      (f_full),
    .w_en        (w_en),
    .mem_data_in (mem_data_in),
    .stage_count (stage_count),
    .ovf_err     (ovf_err)
  );

  always #5 w_clk = ~w_clk;

  // f_full toggles every 8 ns, asynchronous to the 10 ns clock
  always #8 f_tog = ~f_tog;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge w_clk);
    #1;
  endtask

  // Reference model and scoreboard, evaluated 0.5 ns before each edge.
  always begin
    logic exp_wen, exp_rdy;
    @(posedge w_clk);
    #9.5;
    if (mon_en) begin
      exp_rdy = (sb.size() < DEPTH) && !wrst;
      exp_wen = (sb.size() != 0) && !f_full && !wrst;
      chk("w_en",        64'(w_en),        64'(exp_wen));
      chk("wr_ready",    64'(wr_ready),    64'(exp_rdy));
      chk("stage_count", 64'(stage_count), 64'(sb.size()));
      chk("ovf_err",     64'(ovf_err),     64'(m_ovf));
      chk("wen_while_full", 64'(w_en & f_full), 64'd0);
      if (exp_wen) chk("mem_data", 64'(mem_data_in), 64'(sb.pop_front()));
      if (wrst) begin
        sb.delete();
        m_ovf = 1'b0;
      end else if (wr_req) begin
        if (exp_rdy) sb.push_back(data_in);
        else         m_ovf = 1'b1;
      end
    end
  end

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((stage_count != 0 || sb.size() != 0) && n < limit) begin
      cyc();
      n++;
    end
    chk(tag, 64'(stage_count), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int pushes;
    int guard;

    // Reset held with a pending request
    wrst    = 1'b1;
    wr_req  = 1'b1;
    data_in = 32'hA5A5A5A5;
    cyc();
    mon_en  = 1'b1;
    repeat (9) cyc();
    chk("rst_mem_data", 64'(mem_data_in), 64'd0);
    chk("rst_ovf",      64'(ovf_err),     64'd0);
    wrst   = 1'b0;
    wr_req = 1'b0;
    cyc();
    chk("rdy_after_rst", 64'(wr_ready), 64'd1);

    // Three back-to-back pushes, FIFO not full
    f_main = 1'b0;
    foreach (sb[i]) ; // keeps queue untouched; model owns it
    for (int i = 1; i <= 3; i++) begin
      wr_req  = 1'b1;
      data_in = 32'(i * 32'h11);
      cyc();
    end
    wr_req = 1'b0;
    drain("t2_drain", 20);

    // Fill while full, one word overflows
    f_main = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wr_req  = 1'b1;
      data_in = 32'(i);
      cyc();
    end
    wr_req = 1'b0;
    cyc();
    chk("t3_count", 64'(stage_count), 64'(DEPTH));
    chk("t3_ready", 64'(wr_ready),    64'd0);
    chk("t3_ovf",   64'(ovf_err),     64'd1);
    f_main = 1'b0;
    drain("t3_drain", 20);

    // Random words against a toggling full flag
    tog_en = 1'b1;
    pushes = 0;
    guard  = 0;
    while (pushes < 100 && guard < 5000) begin
      if (wr_ready) begin
        wr_req  = 1'b1;
        data_in = $urandom;
        pushes++;
      end else begin
        wr_req = 1'b0;
      end
      cyc();
      guard++;
    end
    wr_req = 1'b0;
    chk("t4_pushes", 64'(pushes), 64'd100);
    drain("t4_drain", 400);
    tog_en = 1'b0;
    f_main = 1'b0;

    // Steady push+pop with two words resident
    f_main = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_req  = 1'b1;
      data_in = 32'hA0 + 32'(i);
      cyc();
    end
    f_main = 1'b0;
    for (int i = 2; i < 8; i++) begin
      data_in = 32'hA0 + 32'(i);
      cyc();
      chk("t5_count", 64'(stage_count), 64'd2);
    end
    wr_req = 1'b0;
    drain("t5_drain", 20);

    // Reset with words queued behind a full FIFO
    f_main = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_req  = 1'b1;
      data_in = 32'hB0 + 32'(i);
      cyc();
    end
    wr_req = 1'b0;
    cyc();
    chk("t6_count_pre", 64'(stage_count), 64'd3);
    wrst = 1'b1;
    cyc();
    chk("t6_count_rst", 64'(stage_count), 64'd0);
    chk("t6_wen_rst",   64'(w_en),        64'd0);
    wrst   = 1'b0;
    f_main = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_wen_after", 64'(w_en), 64'd0);
    end
    wr_req  = 1'b1;
    data_in = 32'hC0;
    cyc();
    wr_req = 1'b0;
    drain("t6_drain", 20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
